// File: rtl/ccff_chain_loader_if.sv
// Host-side bitstream port of the ccff chain loader: one word per valid/ready handshake.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises host words MSB-first into a routing tile's ccff chain, CHAIN_LEN bits per pass,
// with an optional second pass that compares the returning ccff_tail stream to the re-sent bits.
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 36,
  parameter int CNT_W     = 16
) (
  input  logic               prog_clk,
  input  logic               pReset_n,
  input  logic               start,
  input  logic               verify,
  ccff_chain_loader_if.slave cfg,
  output logic               ccff_head,
  output logic               config_enable,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int               WBITS_W     = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WORD_W_C    = CNT_W'(WORD_W);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         pass_q, pass_d;
  logic [1:0]         pass_max_q, pass_max_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [WBITS_W-1:0] wbits_q, wbits_d;
  logic [WORD_W-1:0]  sreg_q, sreg_d;
  logic               head_q, head_d;
  logic               en_q, en_d;
  logic               chk_q, chk_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   remaining;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q    <= IDLE;
      pass_q     <= '0;
      pass_max_q <= '0;
      bitcnt_q   <= '0;
      wbits_q    <= '0;
      sreg_q     <= '0;
      head_q     <= 1'b0;
      en_q       <= 1'b0;
      chk_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      pass_max_q <= pass_max_d;
      bitcnt_q   <= bitcnt_d;
      wbits_q    <= wbits_d;
      sreg_q     <= sreg_d;
      head_q     <= head_d;
      en_q       <= en_d;
      chk_q      <= chk_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // chk_q tags the bit currently on ccff_head as a verify-pass bit, so the
  // compare stays aligned with the registered head rather than with pass_q.
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    pass_max_d = pass_max_q;
    bitcnt_d   = bitcnt_q;
    wbits_d    = wbits_q;
    sreg_d     = sreg_q;
    head_d     = head_q;
    en_d       = 1'b0;
    chk_d      = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q | (chk_q & (ccff_tail != head_q));
    remaining  = CHAIN_LEN_C - bitcnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          pass_max_d = verify ? 2'd2 : 2'd1;
          pass_d     = 2'd1;
          bitcnt_d   = '0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
        end
      end
      FETCH: begin
        if (cfg.cfg_valid) begin
          sreg_d  = cfg.cfg_data;
          wbits_d = (remaining >= WORD_W_C) ? WBITS_W'(WORD_W) : WBITS_W'(remaining);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        head_d   = sreg_q[WORD_W-1];
        en_d     = 1'b1;
        chk_d    = (pass_q == 2'd2);
        sreg_d   = {sreg_q[WORD_W-2:0], 1'b0};
        bitcnt_d = bitcnt_q + CNT_W'(1);
        wbits_d  = wbits_q - WBITS_W'(1);
        if (wbits_q == WBITS_W'(1)) begin
          if (bitcnt_d == CHAIN_LEN_C) begin
            if (pass_q == pass_max_q) begin
              state_d = DONE;
            end else begin
              pass_d   = pass_q + 2'd1;
              bitcnt_d = '0;
              state_d  = FETCH;
            end
          end else begin
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg.cfg_ready  = (state_q == FETCH);
  assign done           = (state_q == DONE);
  assign ccff_head      = head_q;
  assign config_enable  = en_q;
  assign busy           = busy_q;
  assign err            = err_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: drives a 36-flop and a 32-flop instance against
// behavioural chain models and a word-level stream/verify reference.
module tb_ccff_chain_loader;
  logic       prog_clk = 1'b0;
  logic       pReset_n = 1'b0;
  logic       start = 1'b0;
  logic       verify = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  bit         sel = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader_if #(.WORD_W(8)) bus_a ();
  ccff_chain_loader_if #(.WORD_W(8)) bus_b ();

  logic head_a, en_a, busy_a, done_a, err_a, tail_a;
  logic head_b, en_b, busy_b, done_b, err_b, tail_b;
  logic [35:0] chain_a = '0;
  logic [31:0] chain_b = '0;

  assign bus_a.cfg_data  = cfg_data;
  assign bus_a.cfg_valid = cfg_valid & ~sel;
  assign bus_b.cfg_data  = cfg_data;
  assign bus_b.cfg_valid = cfg_valid & sel;

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(36), .CNT_W(16)) dut_a (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start & ~sel), .verify(verify),
    .cfg(bus_a.slave), .ccff_head(head_a), .config_enable(en_a), .ccff_tail(tail_a),
    .busy(busy_a), .done(done_a), .err(err_a));

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(32), .CNT_W(16)) dut_b (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start & sel), .verify(verify),
    .cfg(bus_b.slave), .ccff_head(head_b), .config_enable(en_b), .ccff_tail(tail_b),
    .busy(busy_b), .done(done_b), .err(err_b));

  // The downstream tile: a plain shift chain, first bit ends up in the MSB.
  always @(posedge prog_clk) begin
    if (en_a) chain_a <= {chain_a[34:0], head_a};
    if (en_b) chain_b <= {chain_b[30:0], head_b};
  end
  assign tail_a = chain_a[35];
  assign tail_b = chain_b[31];

  logic obs_head, obs_en, obs_busy, obs_done, obs_err, obs_ready;
  assign obs_head  = sel ? head_b : head_a;
  assign obs_en    = sel ? en_b : en_a;
  assign obs_busy  = sel ? busy_b : busy_a;
  assign obs_done  = sel ? done_b : done_a;
  assign obs_err   = sel ? err_b : err_a;
  assign obs_ready = sel ? bus_b.cfg_ready : bus_a.cfg_ready;

  int           en_cnt = 0;
  int           done_cnt = 0;
  int           pend_idx = 0;
  logic         pend = 1'b0;
  logic [127:0] obs_vec = '0;
  logic         err_after [1024];

  // Records every enabled head bit and the err value one cycle after each such bit.
  always @(negedge prog_clk) begin
    if (pend) err_after[pend_idx % 1024] <= obs_err;
    pend     <= obs_en;
    pend_idx <= en_cnt;
    if (obs_en) begin
      obs_vec <= {obs_vec[126:0], obs_head};
      en_cnt  <= en_cnt + 1;
    end
    if (obs_done) done_cnt <= done_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pass of the stream: the words concatenated MSB-first, truncated to len bits.
  function automatic logic [127:0] passVec(input logic [7:0] w[$], input int first, input int len);
    logic [127:0] v;
    int wpp;
    v   = '0;
    wpp = (len + 7) / 8;
    for (int k = 0; k < wpp; k++) v = (v << 8) | 128'(w[first + k]);
    return v >> (wpp * 8 - len);
  endfunction

  task automatic sendWord(input logic [7:0] w);
    int t;
    t = 0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    while (obs_ready !== 1'b1 && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    checkOutput("ready_wait", 128'(t < 100), 128'(1));
    @(negedge prog_clk);
    cfg_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input bit v, input logic [7:0] w[$],
                               input int gap_after, input bit restart, input int len);
    int t, en0, done0, passes, wpp;
    logic [127:0] p1, p2, exp_stream, mask;
    logic mm;
    passes = v ? 2 : 1;
    wpp    = (len + 7) / 8;
    @(negedge prog_clk);
    en0    = en_cnt;
    done0  = done_cnt;
    start  = 1'b1;
    verify = v;
    @(negedge prog_clk);
    start  = 1'b0;
    verify = 1'b0;
    checkOutput({tag, "_err_clear"}, 128'(obs_err), 128'(0));
    checkOutput({tag, "_busy_on"}, 128'(obs_busy), 128'(1));
    for (int i = 0; i < w.size(); i++) begin
      sendWord(w[i]);
      if (restart && i == 0) begin
        start  = 1'b1;
        verify = ~v;
        @(negedge prog_clk);
        start  = 1'b0;
        verify = 1'b0;
      end
      if (i == gap_after) begin
        repeat (8) @(negedge prog_clk);
        for (int g = 0; g < 10; g++) begin
          @(negedge prog_clk);
          checkOutput({tag, "_gap_enable"}, 128'(obs_en), 128'(0));
        end
      end
    end
    t = 0;
    while (obs_busy && t < 400) begin
      @(negedge prog_clk);
      t++;
    end
    checkOutput({tag, "_done_wait"}, 128'(t < 400), 128'(1));
    repeat (2) @(negedge prog_clk);
    #1;
    p1         = passVec(w, 0, len);
    p2         = v ? passVec(w, wpp, len) : '0;
    exp_stream = v ? ((p1 << len) | p2) : p1;
    mask       = (128'(1) << (passes * len)) - 128'(1);
    checkOutput({tag, "_enables"}, 128'(en_cnt - en0), 128'(passes * len));
    checkOutput({tag, "_stream"}, obs_vec & mask, exp_stream);
    checkOutput({tag, "_done_count"}, 128'(done_cnt - done0), 128'(1));
    checkOutput({tag, "_chain"}, sel ? 128'(chain_b) : 128'(chain_a), v ? p2 : p1);
    checkOutput({tag, "_err"}, 128'(obs_err), 128'(v && (p1 != p2)));
    checkOutput({tag, "_busy_off"}, 128'(obs_busy), 128'(0));
    if (v) begin
      mm = 1'b0;
      for (int j = 0; j < len; j++) begin
        mm = mm | (p1[len-1-j] != p2[len-1-j]);
        checkOutput({tag, "_err_timing"}, 128'(err_after[(en0 + len + j) % 1024]), 128'(mm));
      end
    end
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] base[$];
    logic [7:0] words[$];
    logic [7:0] rnd[$];
    int en_snap, wi, bi;

    // Reset state
    #3;
    checkOutput("rst_ready", 128'(obs_ready), 128'(0));
    checkOutput("rst_head", 128'(obs_head), 128'(0));
    checkOutput("rst_enable", 128'(obs_en), 128'(0));
    checkOutput("rst_busy", 128'(obs_busy), 128'(0));
    checkOutput("rst_done", 128'(obs_done), 128'(0));
    checkOutput("rst_err", 128'(obs_err), 128'(0));
    @(negedge prog_clk);
    pReset_n = 1'b1;

    // T1: asynchronous reset in the middle of a shift
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    sendWord(8'hFF);
    repeat (3) @(negedge prog_clk);
    checkOutput("t1_pre_enable", 128'(obs_en), 128'(1));
    checkOutput("t1_pre_head", 128'(obs_head), 128'(1));
    #2;
    pReset_n = 1'b0;
    #1;
    checkOutput("t1_enable", 128'(obs_en), 128'(0));
    checkOutput("t1_head", 128'(obs_head), 128'(0));
    checkOutput("t1_busy", 128'(obs_busy), 128'(0));
    checkOutput("t1_ready", 128'(obs_ready), 128'(0));
    @(negedge prog_clk);
    pReset_n = 1'b1;

    // cfg_valid in IDLE gets no ready and shifts nothing
    @(negedge prog_clk);
    en_snap   = en_cnt;
    cfg_data  = 8'h77;
    cfg_valid = 1'b1;
    repeat (3) begin
      @(negedge prog_clk);
      checkOutput("idle_ready", 128'(obs_ready), 128'(0));
    end
    cfg_valid = 1'b0;
    @(negedge prog_clk);
    checkOutput("idle_no_shift", 128'(en_cnt), 128'(en_snap));

    base = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h9F};

    // T2: single pass
    applyStimulus("t2", 1'b0, base, -1, 1'b0, 36);

    // T3: verify pass with an identical stream
    words = {base, base};
    applyStimulus("t3", 1'b1, words, -1, 1'b0, 36);

    // T4: pass-2 word 3C corrupted to 3D; err must stick until next start
    words = {base, base};
    words[6] = 8'h3D;
    applyStimulus("t4", 1'b1, words, -1, 1'b0, 36);
    repeat (5) @(negedge prog_clk);
    checkOutput("t4_err_sticky", 128'(obs_err), 128'(1));

    // T5: host stalls between words 2 and 3
    applyStimulus("t5", 1'b0, base, 1, 1'b0, 36);

    // Randomised loads: clean verify, then verify with one flipped pass-2 bit
    rnd.delete();
    for (int k = 0; k < 5; k++) rnd.push_back(8'($urandom));
    words = {rnd, rnd};
    applyStimulus("r1", 1'b1, words, -1, 1'b0, 36);
    rnd.delete();
    for (int k = 0; k < 5; k++) rnd.push_back(8'($urandom));
    words = {rnd, rnd};
    wi = $urandom_range(0, 4);
    bi = $urandom_range(0, 7);
    words[5 + wi] = words[5 + wi] ^ 8'(1 << bi);
    applyStimulus("r2", 1'b1, words, -1, 1'b0, 36);

    // T6: 32-flop chain, start re-pulsed while busy
    sel = 1'b1;
    rnd.delete();
    for (int k = 0; k < 4; k++) rnd.push_back(8'($urandom));
    applyStimulus("t6", 1'b0, rnd, -1, 1'b1, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
